// File: rtl/mux_arbiter_4_pkg.sv
// mux_arbiter_4_pkg: shared state encodings, requester count and default hold limit
package mux_arbiter_4_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    localparam int NUM_REQ      = 4;
    localparam int MAX_HOLD_DEF = 4;
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction
endpackage

// File: rtl/mux_arbiter_4_rr_pick4.sv
// rr_pick4: first asserted, non-excluded request scanning start, start+1, ... modulo 4
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] start,
    input  logic [3:0] excl,
    output logic       found,
    output logic [1:0] idx
);
    logic [3:0] cand;
    logic [3:0] rot;
    always_comb begin
        cand  = req & ~excl;
        found = |cand;
        rot   = 4'({cand, cand} >> start);
        idx   = start;
        for (int k = 3; k >= 0; k--)
            if (rot[k]) idx = start + 2'(k);
    end
endmodule

// File: rtl/mux_arbiter_4.sv
// mux_arbiter_4: round-robin 4-way arbiter with bounded hold and shared 4:1 data select
module mux_arbiter_4
    import mux_arbiter_4_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [4*DATA_W-1:0]   data_in,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [1:0]            sel,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data
);
    localparam logic [3:0] MAXH = 4'(MAX_HOLD);
    state_t     state, state_n;
    logic [1:0] owner, owner_n, ptr, ptr_n, idx;
    logic [3:0] hold_cnt, hold_n;
    logic       found, handoff;
    // ptr always sits at owner+1 while busy, so scanning from ptr with the owner masked
    // yields the first pending requester after the owner
    rr_pick4 u_pick (
        .req   (req),
        .start (ptr),
        .excl  (state == BUSY ? onehot4(owner) : 4'b0000),
        .found (found),
        .idx   (idx)
    );
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        handoff = state == IDLE ? found : found && (!req[owner] || hold_cnt >= MAXH);
        if (handoff) begin
            state_n = BUSY;
            owner_n = idx;
            ptr_n   = idx + 2'd1;
            hold_n  = 4'd1;
        end else if (state == BUSY && !req[owner]) begin
            state_n = IDLE;
            hold_n  = 4'd0;
        end else if (state == BUSY && hold_cnt < MAXH) begin
            hold_n  = hold_cnt + 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 2'd0;
            ptr      <= 2'd0;
            hold_cnt <= 4'd0;
            gnt      <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= state_n == BUSY ? onehot4(owner_n) : 4'b0000;
        end
    end
    assign sel       = owner;
    assign out_valid = state == BUSY && req[owner];
    assign out_data  = out_valid ? data_in[32'(owner)*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_mux_arbiter_4.sv
// tb_mux_arbiter_4: directed checks of the round-robin arbiter, MAX_HOLD=4 and MAX_HOLD=1 instances
module tb_mux_arbiter_4;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt, gnt1;
    logic [1:0]  sel, sel1;
    logic        out_valid, out_valid1;
    logic [7:0]  out_data, out_data1;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mux_arbiter_4 #(.DATA_W(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
    );
    mux_arbiter_4 #(.DATA_W(8), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in),
        .gnt(gnt1), .sel(sel1), .out_valid(out_valid1), .out_data(out_data1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++;
        if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL reset_out got=%b/%h exp=0/00", out_valid, out_data);
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL idle_gnt got=%b exp=0000", gnt); end
    endtask

    task automatic test_rotation();
        logic [3:0] eg;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            tick();
            eg = 4'b0001 << ((i / 4) % 4);
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL rot_gnt cyc=%0d got=%b exp=%b", i, gnt, eg); end
            checks++;
            if (out_data !== 8'h11 * (((i / 4) % 4) + 1)) begin
                failures++; $display("FAIL rot_data cyc=%0d got=%h", i, out_data);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (gnt !== 4'b0100 || sel !== 2'd2) begin
                failures++; $display("FAIL sat_gnt cyc=%0d got=%b/%0d exp=0100/2", i, gnt, sel);
            end
            checks++;
            if (dut.hold_cnt !== 4'((i < 3) ? i + 1 : 4)) begin
                failures++; $display("FAIL sat_hold cyc=%0d got=%0d", i, dut.hold_cnt);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33) begin
                failures++; $display("FAIL sat_data cyc=%0d got=%b/%h exp=1/33", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010;
        tick();
        req = 4'b1010;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL drop_pre got=%b exp=0010", gnt); end
        req = 4'b1000;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL drop_gap got=%b/%h exp=0/00", out_valid, out_data);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            failures++; $display("FAIL drop_gnt got=%b/%0d exp=1000/3", gnt, sel);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h44) begin
            failures++; $display("FAIL drop_out got=%b/%h exp=1/44", out_valid, out_data);
        end
    endtask

    task automatic test_idle();
        req = 4'b0000;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin failures++; $display("FAIL idle_ret_gnt got=%b exp=0000", gnt); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL idle_ret_out got=%b/%h exp=0/00", out_valid, out_data);
        end
        tick();
        checks++;
        if (sel !== 2'd3) begin failures++; $display("FAIL idle_sel_hold got=%0d exp=3", sel); end
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL idle_ptr_wrap got=%b exp=0001", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (gnt !== 4'b0100) begin failures++; $display("FAIL mid_pre got=%b exp=0100", gnt); end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== 4'b0000 || sel !== 2'd0) begin
            failures++; $display("FAIL mid_rst got=%b/%0d exp=0000/0", gnt, sel);
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            failures++; $display("FAIL mid_rst_out got=%b/%h exp=0/00", out_valid, out_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_release got=%b exp=0001", gnt); end
    endtask

    task automatic test_maxhold1();
        logic [3:0] eg;
        do_reset();
        req = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            tick();
            eg = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            checks++;
            if (gnt1 !== eg) begin failures++; $display("FAIL mh1_gnt cyc=%0d got=%b exp=%b", i, gnt1, eg); end
            checks++;
            if (!$onehot(gnt1) || gnt1[sel1] !== 1'b1) begin
                failures++; $display("FAIL mh1_onehot cyc=%0d gnt=%b sel=%0d", i, gnt1, sel1);
            end
            checks++;
            if (out_data1 !== ((i % 2 == 0) ? 8'h22 : 8'h44)) begin
                failures++; $display("FAIL mh1_data cyc=%0d got=%h", i, out_data1);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        test_reset();
        test_rotation();
        test_saturate();
        test_back_to_back();
        test_idle();
        test_reset_mid();
        test_maxhold1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_arbiter_4.md
MUX_ARBITER_4 -- requirements
Module: mux_arbiter_4

Interface
REQ-001 Parameter: DATA_W, 8, width of each requester's data lane.
REQ-002 Parameter: MAX_HOLD, 4, max consecutive grant cycles under contention; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  4  request per requester; req[n] held high while requester n wants the shared path.
REQ-006 Port: data_in  input  4*DATA_W  packed lanes; lane n = data_in[n*DATA_W +: DATA_W].
REQ-007 Port: gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-008 Port: sel  output  2  registered binary index of current owner; drives shared 4:1 select.
REQ-009 Port: out_valid  output  1  high when owner holds grant and its req is high.
REQ-010 Port: out_data  output  DATA_W  lane[sel] when out_valid, else all-zero.

Function
REQ-011 State machine SHALL have two states, IDLE and BUSY, plus registers owner (2b), ptr (2b), hold_cnt (4b).
REQ-012 Round-robin pick SHALL select the first asserted req scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-013 IDLE with req != 0 SHALL grant picked requester on next edge: BUSY, gnt one-hot, sel=owner, hold_cnt=1, ptr=owner+1 mod 4.
REQ-014 Grant latency SHALL be one cycle: req sampled at edge k, gnt visible after edge k.
REQ-015 IDLE with req == 0 SHALL stay IDLE, gnt=0, sel and ptr unchanged.
REQ-016 BUSY with req[owner]=1 and hold_cnt<MAX_HOLD SHALL keep owner and increment hold_cnt.
REQ-017 BUSY with req[owner]=1, hold_cnt==MAX_HOLD, another req pending SHALL hand grant to first pending requester after owner (owner excluded), hold_cnt=1.
REQ-018 BUSY with req[owner]=1, hold_cnt==MAX_HOLD, no other req SHALL keep owner with hold_cnt saturated at MAX_HOLD.
REQ-019 BUSY with req[owner]=0 and other reqs pending SHALL hand off on that same edge with no idle cycle, pick excluding owner.
REQ-020 BUSY with req==0 SHALL return to IDLE and clear gnt; sel holds last value.
REQ-021 Every new grant SHALL set ptr=new owner+1 mod 4; ptr SHALL not change while owner is retained.
REQ-022 out_valid and out_data SHALL be combinational from registered state and current req/data_in; no extra latency.
REQ-023 MAX_HOLD=1 SHALL rotate every cycle under contention.
REQ-024 gnt SHALL never have more than one bit set; gnt[sel]==1 whenever state is BUSY.

Reset
REQ-025 rst high at an edge SHALL force IDLE, gnt=0, sel=0, owner=0, ptr=0, hold_cnt=0, regardless of current state or req.
REQ-026 While rst is high, out_valid=0 and out_data=0 from the first edge with rst sampled.
REQ-027 Reset mid-grant SHALL drop the grant without handoff; first grant after release follows REQ-012 with ptr=0.

Structure
REQ-028 Shared package SHALL hold state encodings (IDLE=0, BUSY=1), NUM_REQ=4 and default MAX_HOLD.
REQ-029 Round-robin pick SHALL be a combinational sub-module rr_pick4 (inputs req, start index, exclude mask; outputs found, index), instantiated once.
REQ-030 Data selection SHALL be a 4:1 select on sel; no storage of data_in.

Verification
REQ-031 Reset, then req=4'b1111 -> gnt=0001 next cycle; under steady contention order 0,1,2,3,0 with MAX_HOLD=4 cycles each.
REQ-032 req=4'b0100 alone for 10 cycles -> gnt=0100 throughout, hold_cnt saturates at 4, out_data=lane2.
REQ-033 Owner 1 drops req while req[3]=1 -> gnt=1000 on the next edge, out_valid gap of exactly the drop cycle only.
REQ-034 req goes 0000 during BUSY -> IDLE, gnt=0000, out_valid=0, out_data=0 next cycle.
REQ-035 rst asserted during owner 2 grant with req=1111 -> gnt=0000 after edge; after release gnt=0001.
REQ-036 MAX_HOLD=1, req=4'b1010 -> gnt alternates 0010,1000 every cycle; one-hot assertion checked every cycle.
